// File: rtl/mc_cu.sv
// mc_cu: multi-cycle RV32I control unit.
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. It handshakes with
// instruction and data memory, drives the datapath selects and ALU op, counts retired
// instructions, and parks in TRAP on a memory timeout or an illegal opcode.
module mc_cu #(
  parameter int TIMEOUT      = 16,    // max wait cycles for a memory ack; 0 disables the timeout
  parameter bit ILLEGAL_TRAP = 1'b1,  // 1: illegal opcode traps, 0: treated as a NOP
  parameter int RET_W        = 32     // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             func7,
  input  logic             branchtrue,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pcsel,
  output logic [1:0]       opA,
  output logic             opB,
  output logic [1:0]       immsel,
  output logic [3:0]       alucontrol,
  output logic             bands,
  output logic             regfile,
  output logic             writeback,
  output logic [RET_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  // FSM states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // Instruction classes latched in DECODE
  localparam logic [3:0] CL_NONE  = 4'd0;
  localparam logic [3:0] CL_R     = 4'd1;
  localparam logic [3:0] CL_I     = 4'd2;
  localparam logic [3:0] CL_S     = 4'd3;
  localparam logic [3:0] CL_L     = 4'd4;
  localparam logic [3:0] CL_LUI   = 4'd5;
  localparam logic [3:0] CL_AUIPC = 4'd6;
  localparam logic [3:0] CL_JAL   = 4'd7;
  localparam logic [3:0] CL_JALR  = 4'd8;
  localparam logic [3:0] CL_B     = 4'd9;

  // ALU operations
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // Trap causes
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_IMEM    = 2'b01;
  localparam logic [1:0] TC_ILLEGAL = 2'b10;
  localparam logic [1:0] TC_DMEM    = 2'b11;

  // Wait counter only has to reach TIMEOUT-1: the cycle at that count is the last one allowed.
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [3:0]       iclass_q, iclass_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RET_W-1:0] instret_q, instret_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout_hit;

  // Opcode to class; B-type with func3 010/011 has no encoding and counts as illegal.
  function automatic logic [3:0] decode_class(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: decode_class = CL_R;
      7'b0010011: decode_class = CL_I;
      7'b0100011: decode_class = CL_S;
      7'b0000011: decode_class = CL_L;
      7'b0110111: decode_class = CL_LUI;
      7'b0010111: decode_class = CL_AUIPC;
      7'b1101111: decode_class = CL_JAL;
      7'b1100111: decode_class = CL_JALR;
      7'b1100011: decode_class = (f3[2:1] == 2'b01) ? CL_NONE : CL_B;
      default:    decode_class = CL_NONE;
    endcase
  endfunction

  // Arithmetic op from func3; func7 picks SUB only when allowed (R-type) and SRA always.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7,
                                          input logic sub_ok);
    case (f3)
      3'b000:  arith_op = (sub_ok && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);
  assign instret     = instret_q;
  assign trap_cause  = cause_q;

  // State register, class latch, wait counter, retire counter and trap cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iclass_q   <= CL_NONE;
      wait_cnt_q <= '0;
      instret_q  <= '0;
      cause_q    <= TC_NONE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q    <= state_d;
      iclass_q   <= iclass_d;
      wait_cnt_q <= wait_cnt_d;
      instret_q  <= instret_d;
      cause_q    <= cause_d;
    end
  end

  // Next-state logic plus the handshake, PC and register-file strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    iclass_d   = iclass_q;
    wait_cnt_d = wait_cnt_q;
    instret_d  = instret_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pcsel      = 2'b00;
    regfile    = 1'b0;
    writeback  = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // An ack on the terminal count still wins over the timeout.
          ir_we      = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_DECODE;
        end else if (timeout_hit) begin
          cause_d = TC_IMEM;
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        iclass_d = decode_class(opcode, func3);
        if (decode_class(opcode, func3) != CL_NONE) begin
          state_d = S_EXEC;
        end else if (ILLEGAL_TRAP) begin
          cause_d = TC_ILLEGAL;
          state_d = S_TRAP;
        end else begin
          // Skip the word: step PC, do not retire.
          pc_we      = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end

      S_EXEC: begin
        if (iclass_q == CL_B) begin
          pc_we      = 1'b1;
          pcsel      = branchtrue ? 2'b01 : 2'b00;
          instret_d  = instret_q + RET_W'(1);
          wait_cnt_d = '0;
          state_d    = S_FETCH;
        end else if (iclass_q == CL_L || iclass_q == CL_S) begin
          wait_cnt_d = '0;
          state_d    = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iclass_q == CL_S);
        if (dmem_ack) begin
          wait_cnt_d = '0;
          if (iclass_q == CL_S) begin
            pc_we     = 1'b1;
            instret_d = instret_q + RET_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          cause_d = TC_DMEM;
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        regfile    = 1'b1;
        pc_we      = 1'b1;
        writeback  = (iclass_q == CL_L);
        pcsel      = (iclass_q == CL_JAL)  ? 2'b10 :
                     (iclass_q == CL_JALR) ? 2'b11 : 2'b00;
        instret_d  = instret_q + RET_W'(1);
        wait_cnt_d = '0;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand, immediate and ALU selects, held from EXEC through MEM and WB.
  always_comb begin
    opA        = 2'b00;
    opB        = 1'b0;
    immsel     = 2'b00;
    alucontrol = ALU_ADD;
    bands      = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (iclass_q)
        CL_R: begin
          opA        = 2'b01;
          alucontrol = arith_op(func3, func7, 1'b1);
        end
        CL_I: begin
          opA        = 2'b01;
          opB        = 1'b1;
          alucontrol = arith_op(func3, func7, 1'b0);
        end
        CL_L, CL_JALR: begin
          opA = 2'b01;
          opB = 1'b1;
        end
        CL_S: begin
          opA    = 2'b01;
          opB    = 1'b1;
          immsel = 2'b01;
          bands  = 1'b1;
        end
        CL_LUI: begin
          opA        = 2'b11;
          opB        = 1'b1;
          immsel     = 2'b10;
          alucontrol = ALU_PASSB;
        end
        CL_AUIPC: begin
          opA    = 2'b10;
          opB    = 1'b1;
          immsel = 2'b10;
        end
        CL_JAL: begin
          opA    = 2'b10;
          opB    = 1'b1;
          immsel = 2'b11;
        end
        CL_B: begin
          opA        = 2'b01;
          immsel     = 2'b11;
          bands      = 1'b1;
          alucontrol = (func3[2:1] == 2'b00) ? ALU_SUB :
                       (func3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
        end
        default: begin
          opA = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed bench for mc_cu. Three instances share one stimulus:
//   u0 defaults (TIMEOUT 16, illegal traps), u1 TIMEOUT 4, u2 illegal-as-NOP with a 2-bit counter.
module tb_mc_cu;

  logic       clk, rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7, branchtrue, imem_ack, dmem_ack;

  logic       imem_req [3];
  logic       dmem_req [3];
  logic       dmem_we  [3];
  logic       ir_we    [3];
  logic       pc_we    [3];
  logic       opB      [3];
  logic       bands    [3];
  logic       regfile  [3];
  logic       writeback[3];
  logic       trap     [3];
  logic [1:0] pcsel    [3];
  logic [1:0] opA      [3];
  logic [1:0] immsel   [3];
  logic [1:0] trap_cause[3];
  logic [3:0] alucontrol[3];
  logic [31:0] instret0, instret1;
  logic [1:0]  instret2;

  int n_checks = 0;
  int n_fail   = 0;

  mc_cu #(.TIMEOUT(16), .ILLEGAL_TRAP(1'b1), .RET_W(32)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .branchtrue(branchtrue), .imem_req(imem_req[0]), .imem_ack(imem_ack),
    .dmem_req(dmem_req[0]), .dmem_we(dmem_we[0]), .dmem_ack(dmem_ack), .ir_we(ir_we[0]),
    .pc_we(pc_we[0]), .pcsel(pcsel[0]), .opA(opA[0]), .opB(opB[0]), .immsel(immsel[0]),
    .alucontrol(alucontrol[0]), .bands(bands[0]), .regfile(regfile[0]),
    .writeback(writeback[0]), .instret(instret0), .trap(trap[0]), .trap_cause(trap_cause[0]));

  mc_cu #(.TIMEOUT(4), .ILLEGAL_TRAP(1'b1), .RET_W(32)) u1 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .branchtrue(branchtrue), .imem_req(imem_req[1]), .imem_ack(imem_ack),
    .dmem_req(dmem_req[1]), .dmem_we(dmem_we[1]), .dmem_ack(dmem_ack), .ir_we(ir_we[1]),
    .pc_we(pc_we[1]), .pcsel(pcsel[1]), .opA(opA[1]), .opB(opB[1]), .immsel(immsel[1]),
    .alucontrol(alucontrol[1]), .bands(bands[1]), .regfile(regfile[1]),
    .writeback(writeback[1]), .instret(instret1), .trap(trap[1]), .trap_cause(trap_cause[1]));

  mc_cu #(.TIMEOUT(16), .ILLEGAL_TRAP(1'b0), .RET_W(2)) u2 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .branchtrue(branchtrue), .imem_req(imem_req[2]), .imem_ack(imem_ack),
    .dmem_req(dmem_req[2]), .dmem_we(dmem_we[2]), .dmem_ack(dmem_ack), .ir_we(ir_we[2]),
    .pc_we(pc_we[2]), .pcsel(pcsel[2]), .opA(opA[2]), .opB(opB[2]), .immsel(immsel[2]),
    .alucontrol(alucontrol[2]), .bands(bands[2]), .regfile(regfile[2]),
    .writeback(writeback[2]), .instret(instret2), .trap(trap[2]), .trap_cause(trap_cause[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the state entered at that edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    func3  = f3;
    func7  = f7;
  endtask

  // Assert reset for one edge, check the cleared outputs, release; returns in IDLE.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branchtrue = 1'b0;
    #1;
    check("rst_trap", trap[0], 1'b0);
    check("rst_instret", instret0, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("idle_imem_req", imem_req[0], 1'b0);
  endtask

  // Table for ALU/operand/pcsel decode; chk=0 skips alu/opA (not defined for JAL).
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       chk;
    logic [3:0] alu;
    logic [1:0] opa;
    logic [1:0] pcs;
  } vec_t;

  vec_t tbl [13];

  int n_req;

  initial begin
    tbl = '{
      '{7'b0110011, 3'b000, 1'b0, 1'b1, 4'b0000, 2'b01, 2'b00},  // ADD
      '{7'b0110011, 3'b000, 1'b1, 1'b1, 4'b0001, 2'b01, 2'b00},  // SUB
      '{7'b0110011, 3'b101, 1'b1, 1'b1, 4'b0110, 2'b01, 2'b00},  // SRA
      '{7'b0110011, 3'b101, 1'b0, 1'b1, 4'b0101, 2'b01, 2'b00},  // SRL
      '{7'b0110011, 3'b011, 1'b0, 1'b1, 4'b1001, 2'b01, 2'b00},  // SLTU
      '{7'b0110011, 3'b100, 1'b1, 1'b1, 4'b0100, 2'b01, 2'b00},  // XOR, func7 ignored
      '{7'b0010011, 3'b000, 1'b1, 1'b1, 4'b0000, 2'b01, 2'b00},  // ADDI, func7 ignored
      '{7'b0010011, 3'b101, 1'b1, 1'b1, 4'b0110, 2'b01, 2'b00},  // SRAI
      '{7'b0010011, 3'b111, 1'b0, 1'b1, 4'b0010, 2'b01, 2'b00},  // ANDI
      '{7'b0110111, 3'b000, 1'b0, 1'b1, 4'b1010, 2'b11, 2'b00},  // LUI
      '{7'b0010111, 3'b000, 1'b0, 1'b1, 4'b0000, 2'b10, 2'b00},  // AUIPC
      '{7'b1100111, 3'b000, 1'b0, 1'b1, 4'b0000, 2'b01, 2'b11},  // JALR
      '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b10}   // JAL
    };

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branchtrue = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0);
    #1;
    check("reset_imem_req", imem_req[0], 1'b0);
    check("reset_dmem_req", dmem_req[0], 1'b0);
    check("reset_pc_we", pc_we[0], 1'b0);
    check("reset_alu", alucontrol[0], 4'b0000);
    check("reset_trap_cause", trap_cause[0], 2'b00);
    check("reset_instret", instret0, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("t1_idle_imem_req", imem_req[0], 1'b0);

    // 1: ADD with immediate ack
    cyc();
    set_instr(7'b0110011, 3'b000, 1'b0); imem_ack = 1'b1; #1;
    check("t1_fetch_req", imem_req[0], 1'b1);
    check("t1_fetch_ir_we", ir_we[0], 1'b1);
    cyc(); imem_ack = 1'b0; #1;
    check("t1_decode_req", imem_req[0], 1'b0);
    check("t1_decode_ir_we", ir_we[0], 1'b0);
    cyc(); #1;
    check("t1_exec_alu", alucontrol[0], 4'b0000);
    check("t1_exec_opA", opA[0], 2'b01);
    check("t1_exec_regfile", regfile[0], 1'b0);
    cyc(); #1;
    check("t1_wb_regfile", regfile[0], 1'b1);
    check("t1_wb_pc_we", pc_we[0], 1'b1);
    check("t1_wb_pcsel", pcsel[0], 2'b00);
    check("t1_wb_writeback", writeback[0], 1'b0);
    cyc(); #1;
    check("t1_cycle5_fetch", imem_req[0], 1'b1);
    check("t1_instret", instret0, 32'd1);

    // 2: LW, dmem_ack 3 cycles late (u1 sees the ack on its terminal count)
    do_reset();
    cyc();
    set_instr(7'b0000011, 3'b010, 1'b0); imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); #1;
    check("t2_exec_alu", alucontrol[0], 4'b0000);
    check("t2_exec_opB", opB[0], 1'b1);
    cyc();
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (dmem_req[0]) n_req++;
      check("t2_mem_dmem_we", dmem_we[0], 1'b0);
      cyc();
    end
    check("t2_dmem_req_cycles", n_req, 4);
    dmem_ack = 1'b0; #1;
    check("t2_wb_dmem_req", dmem_req[0], 1'b0);
    check("t2_wb_writeback", writeback[0], 1'b1);
    check("t2_wb_regfile", regfile[0], 1'b1);
    check("t2_u1_ack_wins", trap[1], 1'b0);
    cyc(); #1;
    check("t2_instret", instret0, 32'd1);
    check("t2_u1_instret", instret1, 32'd1);

    // 3: BEQ taken, then BLTU not taken
    do_reset();
    cyc();
    set_instr(7'b1100011, 3'b000, 1'b0); branchtrue = 1'b1; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    check("t3_decode_regfile", regfile[0], 1'b0);
    cyc(); #1;
    check("t3_exec_alu", alucontrol[0], 4'b0001);
    check("t3_exec_pc_we", pc_we[0], 1'b1);
    check("t3_exec_pcsel", pcsel[0], 2'b01);
    check("t3_exec_bands", bands[0], 1'b1);
    check("t3_exec_regfile", regfile[0], 1'b0);
    cyc(); #1;
    check("t3_next_fetch", imem_req[0], 1'b1);
    check("t3_instret", instret0, 32'd1);
    set_instr(7'b1100011, 3'b110, 1'b0); branchtrue = 1'b0; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); #1;
    check("t3_bltu_alu", alucontrol[0], 4'b1001);
    check("t3_bltu_pcsel", pcsel[0], 2'b00);
    check("t3_bltu_pc_we", pc_we[0], 1'b1);
    cyc(); #1;
    check("t3_instret2", instret0, 32'd2);

    // ALU / operand / pcsel decode table; u2 counter wraps modulo 4
    do_reset();
    cyc();
    foreach (tbl[k]) begin
      set_instr(tbl[k].op, tbl[k].f3, tbl[k].f7); imem_ack = 1'b1;
      cyc(); imem_ack = 1'b0;
      cyc(); #1;
      if (tbl[k].chk) begin
        check($sformatf("tbl%0d_alu", k), alucontrol[0], tbl[k].alu);
        check($sformatf("tbl%0d_opA", k), opA[0], tbl[k].opa);
      end
      cyc(); #1;
      check($sformatf("tbl%0d_wb_pcsel", k), pcsel[0], tbl[k].pcs);
      check($sformatf("tbl%0d_wb_regfile", k), regfile[0], 1'b1);
      cyc();
    end
    #1;
    check("tbl_instret", instret0, 32'd13);
    check("tbl_instret_wrap", instret2, 2'd1);

    // 4: fetch timeout on u1 (TIMEOUT 4)
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_fetch_req", imem_req[1], 1'b1);
      cyc();
    end
    #1;
    check("t4_trap", trap[1], 1'b1);
    check("t4_cause", trap_cause[1], 2'b01);
    check("t4_trap_imem_req", imem_req[1], 1'b0);
    check("t4_u0_not_trapped", trap[0], 1'b0);
    imem_ack = 1'b1;
    repeat (3) cyc();
    #1;
    check("t4_trap_held", trap[1], 1'b1);
    check("t4_cause_held", trap_cause[1], 2'b01);
    check("t4_trap_pc_we", pc_we[1], 1'b0);
    do_reset();
    check("t4_rst_clears_trap", trap[1], 1'b0);
    check("t4_rst_clears_cause", trap_cause[1], 2'b00);

    // Fetch ack on the terminal count wins
    cyc();
    set_instr(7'b0110011, 3'b000, 1'b0);
    repeat (3) cyc();
    imem_ack = 1'b1; #1;
    check("t4_last_ir_we", ir_we[1], 1'b1);
    cyc(); imem_ack = 1'b0; #1;
    check("t4_last_no_trap", trap[1], 1'b0);
    check("t4_last_decode", imem_req[1], 1'b0);

    // Data-memory timeout on u1
    do_reset();
    cyc();
    set_instr(7'b0000011, 3'b010, 1'b0); imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); cyc();
    repeat (4) cyc();
    #1;
    check("dto_trap", trap[1], 1'b1);
    check("dto_cause", trap_cause[1], 2'b11);
    check("dto_dmem_req", dmem_req[1], 1'b0);
    check("dto_u0_waiting", dmem_req[0], 1'b1);

    // 5: illegal opcode
    do_reset();
    cyc();
    set_instr(7'b1111111, 3'b000, 1'b0); imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    check("t5_nop_pc_we", pc_we[2], 1'b1);
    check("t5_nop_pcsel", pcsel[2], 2'b00);
    check("t5_trap_pc_we", pc_we[0], 1'b0);
    cyc(); #1;
    check("t5_trap", trap[0], 1'b1);
    check("t5_cause", trap_cause[0], 2'b10);
    check("t5_nop_fetch", imem_req[2], 1'b1);
    check("t5_nop_instret", instret2, 2'd0);
    check("t5_nop_no_trap", trap[2], 1'b0);
    do_reset();
    cyc();
    set_instr(7'b1100011, 3'b010, 1'b0); imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); #1;
    check("t5_bad_branch_cause", trap_cause[0], 2'b10);

    // 6: SW completes, second SW aborted by reset in MEM
    do_reset();
    cyc();
    set_instr(7'b0110011, 3'b000, 1'b0); imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); cyc(); cyc();
    set_instr(7'b0100011, 3'b010, 1'b0); imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); #1;
    check("t6_exec_immsel", immsel[0], 2'b01);
    check("t6_exec_bands", bands[0], 1'b1);
    cyc();
    dmem_ack = 1'b1; #1;
    check("t6_sw_dmem_req", dmem_req[0], 1'b1);
    check("t6_sw_dmem_we", dmem_we[0], 1'b1);
    check("t6_sw_pc_we", pc_we[0], 1'b1);
    check("t6_sw_pcsel", pcsel[0], 2'b00);
    cyc(); dmem_ack = 1'b0; #1;
    check("t6_sw_fetch", imem_req[0], 1'b1);
    check("t6_sw_instret", instret0, 32'd2);
    imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc(); cyc(); #1;
    check("t6_mem_dmem_req", dmem_req[0], 1'b1);
    rst = 1'b1; #1;
    check("t6_rst_dmem_req", dmem_req[0], 1'b0);
    check("t6_rst_instret", instret0, 32'd0);
    cyc();
    rst = 1'b0; #1;
    check("t6_idle", imem_req[0], 1'b0);
    cyc(); #1;
    check("t6_fetch", imem_req[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
